// File: rtl/hft_pkg.sv
// Shared types and constants for the order-entry datapath.
package hft_pkg;

  localparam int ADDR_W    = 8;
  localparam int BUYSELL_W = 8;

  localparam logic [BUYSELL_W-1:0] BS_HOLD = 8'd0;
  localparam logic [BUYSELL_W-1:0] BS_BUY  = 8'd1;
  localparam logic [BUYSELL_W-1:0] BS_SELL = 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request strictly after ptr, with wrap.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] j;

  // Scan ptr+1 .. ptr+N so the last winner is considered last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    j       = '0;
    for (int i = 1; i <= N; i++) begin
      j = IDX_W'((int'(ptr) + i) % N);
      if (!any_req && req[j]) begin
        any_req = 1'b1;
        winner  = j;
      end
    end
  end

endmodule

// File: rtl/tx_order_arbiter.sv
// Round-robin arbiter sharing the single timestamp/tx_mux path among order requesters.
module tx_order_arbiter
  import hft_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*BUYSELL_W-1:0]   req_buysell,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [ADDR_W-1:0]              tx_addr,
  output logic [BUYSELL_W-1:0]           tx_buysell,
  output logic                           tx_start,
  input  logic                           tx_done,
  output logic                           busy,
  output logic                           timeout_err,
  output logic [CNT_W-1:0]               drop_count,
  output logic [CNT_W-1:0]               timeout_count,
  output logic [CNT_W-1:0]               stray_done_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [TMO_W-1:0] tmo_cnt;

  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [BUYSELL_W-1:0] bs_arr   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign bs_arr[g]   = req_buysell[g*BUYSELL_W +: BUYSELL_W];
  end

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      ptr              <= IDX_W'(NUM_REQ - 1);
      tmo_cnt          <= '0;
      tx_addr          <= '0;
      tx_buysell       <= '0;
      req_ack          <= '0;
      tx_start         <= 1'b0;
      timeout_err      <= 1'b0;
      drop_count       <= '0;
      timeout_count    <= '0;
      stray_done_count <= '0;
    end else begin
      req_ack     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;

      if (tx_done && state != ST_WAIT && !(&stray_done_count))
        stray_done_count <= stray_done_count + 1'b1;

      unique case (state)
        // Ack and tx_start are issued from here so they appear in the GRANT cycle.
        ST_IDLE: begin
          if (any_req) begin
            tx_addr         <= addr_arr[winner];
            tx_buysell      <= bs_arr[winner];
            ptr             <= winner;
            req_ack[winner] <= 1'b1;
            tx_start        <= (bs_arr[winner] != BS_HOLD);
            state           <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (tx_buysell != BS_HOLD) begin
            state <= ST_WAIT;
          end else begin
            if (!(&drop_count)) drop_count <= drop_count + 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (tx_done) begin
            tmo_cnt <= '0;
            state   <= ST_IDLE;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            if (!(&timeout_count)) timeout_count <= timeout_count + 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
